ula_cmd_sched: RTL and testbench
================================

Name: ula_cmd_sched

Overview:
- Command scheduler that sits directly upstream of the 6-bit ULA and also collects its registered results.
- Accepts operation requests {A, B, operacao, modo} over a valid/ready handshake and buffers them in a small FIFO.
- Issues one request at a time to the ULA, holding its operand inputs stable, then captures ula_out/carry_out/zero one cycle later.
- Returns each result, in request order, over a second valid/ready handshake.

Parameters:
- WIDTH, 6, operand/result width; must match the ULA.
- OP_W, 3, operacao width.
- DEPTH, 4, command FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous reset, active-low
- cmd_valid  in  1  request present
- cmd_ready  out  1  FIFO can accept; equals !full
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B
- cmd_op  in  OP_W  operacao
- cmd_modo  in  1  1 = logic, 0 = arithmetic
- alu_a  out  WIDTH  to ULA A
- alu_b  out  WIDTH  to ULA B
- alu_op  out  OP_W  to ULA operacao
- alu_modo  out  1  to ULA modo
- alu_res  in  WIDTH  from ULA ula_out
- alu_carry  in  1  from ULA carry_out
- alu_zero  in  1  from ULA zero
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts
- res_data  out  WIDTH  captured result
- res_carry  out  1  captured carry; forced 0 when the op was a logic op
- res_zero  out  1  captured zero flag
- level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=0, async): FIFO empty, level=0, cmd_ready=1, FSM=IDLE, res_valid=0, res_data=0, res_carry=0, res_zero=0, alu_a=alu_b=0, alu_op=0, alu_modo=0.
- Push: on an edge with cmd_valid && cmd_ready.
- Full FIFO: cmd_ready is computed from registered level only. When full, a push is refused even if a pop occurs in the same cycle.
- Pop: performed only by the FSM. A push and a pop in the same edge on a non-full FIFO leave level unchanged.
- Pointers: wrap modulo DEPTH.
- Operand registers alu_*: loaded only on a pop. They hold their value otherwise, so the ULA always sees stable inputs.
- FSM states: IDLE, ISSUE, CAPTURE, HOLD.
  - IDLE: if level != 0, pop into alu_* and go to ISSUE; else stay.
  - ISSUE: alu_* are stable; the ULA registers its result on this edge. Go to CAPTURE.
  - CAPTURE: load res_data=alu_res, res_zero=alu_zero, res_carry=alu_modo ? 0 : alu_carry; set res_valid=1; go to HOLD.
  - HOLD: res_valid=1 and all res_* outputs are frozen.
    - On res_ready: clear res_valid. If level != 0, pop in the same edge and go to ISSUE; else go to IDLE.
    - Without res_ready: stay in HOLD indefinitely.
- Latency: a command pushed into an empty, idle scheduler at edge E0 yields res_valid=1 after edge E3.
- Throughput: one result per 3 cycles under continuous res_ready.
- Ordering: strict FIFO; no reordering and no drops.
- Arithmetic: none internally; the ULA's result is passed through unmodified.
- Mid-operation reset: the in-flight command and all queued commands are discarded; outputs return to reset values immediately.
- ULA integration: the ULA's own reset is handled at top level. The scheduler never relies on ULA reset state, since every result is captured only after a fresh issue.

Decomposition:
- Package ula_pkg:
  - ULA_W=6, ULA_OP_W=3.
  - typedef ula_cmd_t packed struct {modo, op, a, b}.
  - typedef sched_state_t enum {IDLE, ISSUE, CAPTURE, HOLD}.
  - op-code localparams OP_AND, OP_ADD, etc.
- Sub-module: ula_cmd_fifo, a parameterised synchronous FIFO of ula_cmd_t with push/pop/full/empty/level and the same async active-low reset. The top level holds the FSM, operand registers and result registers.

Test Plan:
- Reset: hold rst=0 with random inputs -> cmd_ready=1, res_valid=0, level=0, alu_a=0, res_data=0. After release, outputs are unchanged until the first push.
- Add with carry: push A=40, B=30, modo=0, op=000 at E0 -> alu_a=40 after E1. After E3: res_valid=1, res_data=6, res_carry=1, res_zero=0.
- Logic XOR: push A=B=6'h2A, modo=1, op=100 with a stale ULA carry_out of 1 -> res_data=0, res_zero=1, res_carry=0 (forced).
- Backpressure/full with DEPTH=4, res_ready=0: push 6 commands -> 5 accepted (1 issued, 4 queued), level=4, cmd_ready=0. Then assert res_ready -> 5 results in push order; cmd_ready=1 again after the first pop.
- Streaming with res_ready=1: queue A+1 for A=0..3 (modo=0, op=100) -> res_data 1, 2, 3, 4. res_valid is high one cycle in every three.
- Mid-op reset: drop rst during CAPTURE with 2 commands queued -> res_valid=0 and level=0 immediately. After release, pushing B-1 with B=0 (op=111) gives res_data=63 and res_carry equal to the ULA's carry_out.

Source files
------------

// File: rtl/ula_pkg.sv
// ula_pkg: shared types and constants for the ULA command scheduler.
//   ULA_W / ULA_OP_W : operand and operacao widths of the 6-bit ULA
//   ula_cmd_t        : one queued request {modo, op, a, b}
//   sched_state_t    : scheduler FSM states
//   OP_*             : operacao encodings (meaning depends on modo)
package ula_pkg;

  localparam int ULA_W    = 6;
  localparam int ULA_OP_W = 3;

  // Arithmetic mode (modo = 0)
  localparam logic [ULA_OP_W-1:0] OP_ADD   = 3'b000;  // A + B
  localparam logic [ULA_OP_W-1:0] OP_SUB   = 3'b001;  // A - B
  localparam logic [ULA_OP_W-1:0] OP_INC_A = 3'b100;  // A + 1
  localparam logic [ULA_OP_W-1:0] OP_DEC_B = 3'b111;  // B - 1
  // Logic mode (modo = 1)
  localparam logic [ULA_OP_W-1:0] OP_AND   = 3'b000;
  localparam logic [ULA_OP_W-1:0] OP_OR    = 3'b001;
  localparam logic [ULA_OP_W-1:0] OP_NOT_A = 3'b011;
  localparam logic [ULA_OP_W-1:0] OP_XOR   = 3'b100;

  typedef struct packed {
    logic                modo;
    logic [ULA_OP_W-1:0] op;
    logic [ULA_W-1:0]    a;
    logic [ULA_W-1:0]    b;
  } ula_cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} sched_state_t;

endpackage

// File: rtl/ula_cmd_fifo.sv
// ula_cmd_fifo: synchronous FIFO of ula_cmd_t, DEPTH entries (power of two).
//   clk, rst     : clock, async active-low reset (empties the FIFO)
//   push, din    : write request; ignored when full
//   pop, dout    : read request; dout is the head entry (show-ahead)
//   full, empty  : derived from the registered occupancy
//   level        : occupancy 0..DEPTH
module ula_cmd_fifo
  import ula_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  ula_cmd_t      din,
  input  logic          pop,
  output ula_cmd_t      dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  ula_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push_ok, pop_ok;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  // A full FIFO refuses a push even if the same edge pops.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset: nothing is read until level says it is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ula_cmd_sched.sv
// ula_cmd_sched: command scheduler in front of the registered 6-bit ULA.
//   clk, rst                         : clock, async active-low reset
//   cmd_valid/cmd_ready, cmd_*       : request handshake into the FIFO
//   alu_a/alu_b/alu_op/alu_modo      : operand registers driving the ULA
//   alu_res/alu_carry/alu_zero       : registered ULA outputs
//   res_valid/res_ready, res_*       : in-order result handshake
//   level                            : FIFO occupancy
// One command is in flight at a time: pop -> ISSUE (ULA registers its
// result) -> CAPTURE (result sampled) -> HOLD (until consumer takes it).
module ula_cmd_sched
  import ula_pkg::*;
#(
  parameter  int WIDTH = ULA_W,
  parameter  int OP_W  = ULA_OP_W,
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_a,
  input  logic [WIDTH-1:0]  cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic              cmd_modo,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_modo,
  input  logic [WIDTH-1:0]  alu_res,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WIDTH-1:0]  res_data,
  output logic              res_carry,
  output logic              res_zero,
  output logic [LW-1:0]     level
);

  sched_state_t state;
  ula_cmd_t     cmd_in, head;
  logic         fifo_full, fifo_empty;
  logic         push, pop;

  assign cmd_in    = '{modo: cmd_modo, op: cmd_op, a: cmd_a, b: cmd_b};
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;

  // Pops happen only when the ULA is free: from IDLE, or from HOLD on the
  // same edge the consumer takes the previous result.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = !fifo_empty;
      HOLD:    pop = res_ready && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  ula_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (cmd_in),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_modo  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
    end else begin
      // Operands change only on a pop, so the ULA sees stable inputs
      // for the whole ISSUE/CAPTURE/HOLD window.
      if (pop) begin
        alu_a    <= head.a;
        alu_b    <= head.b;
        alu_op   <= head.op;
        alu_modo <= head.modo;
      end
      case (state)
        IDLE:    if (pop) state <= ISSUE;
        ISSUE:   state <= CAPTURE;
        CAPTURE: begin
          res_data  <= alu_res;
          res_zero  <= alu_zero;
          // Logic ops leave the ULA carry stale; never pass it on.
          res_carry <= alu_modo ? 1'b0 : alu_carry;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= pop ? ISSUE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_cmd_sched.sv
// tb_ula_cmd_sched: directed bench with a registered ULA model and an
// in-order result scoreboard.
module tb_ula_cmd_sched;
  import ula_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_modo;
  logic [5:0] cmd_a, cmd_b;
  logic [2:0] cmd_op;
  logic [5:0] alu_a, alu_b, alu_res;
  logic [2:0] alu_op;
  logic       alu_modo, alu_carry, alu_zero;
  logic       res_valid, res_ready, res_carry, res_zero;
  logic [5:0] res_data;
  logic [2:0] level;

  always #5 clk = ~clk;

  ula_cmd_sched #(.WIDTH(6), .OP_W(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_modo(cmd_modo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_modo(alu_modo),
    .alu_res(alu_res), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry), .res_zero(res_zero),
    .level(level)
  );

  // Registered ULA model. Logic ops keep the previous carry (stale).
  function automatic logic [6:0] ula_calc(input logic m, input logic [2:0] op,
                                          input logic [5:0] a, input logic [5:0] b);
    if (!m) begin
      case (op)
        3'b000:  return {1'b0, a} + {1'b0, b};
        3'b001:  return {1'b0, a} - {1'b0, b};
        3'b100:  return {1'b0, a} + 7'd1;
        3'b111:  return {1'b0, b} - 7'd1;
        default: return {1'b0, a};
      endcase
    end else begin
      case (op)
        3'b000:  return {1'b0, a & b};
        3'b001:  return {1'b0, a | b};
        3'b011:  return {1'b0, ~a};
        3'b100:  return {1'b0, a ^ b};
        default: return {1'b0, a};
      endcase
    end
  endfunction

  logic [6:0] ula_t;
  assign ula_t = ula_calc(alu_modo, alu_op, alu_a, alu_b);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_res   <= '0;
      alu_carry <= 1'b0;
      alu_zero  <= 1'b0;
    end else begin
      alu_res  <= ula_t[5:0];
      alu_zero <= (ula_t[5:0] == 6'd0);
      if (!alu_modo) alu_carry <= ula_t[6];
    end
  end

  typedef struct packed {
    logic [5:0] d;
    logic       c;
    logic       z;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   stamps[$];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Result monitor: inputs change at posedge+2, so negedge sees the values
  // that the next posedge will act on.
  always @(negedge clk) begin
    if (rst === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
      chk("result_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("res_data", 32'(res_data), 32'(mon_e.d));
        chk("res_carry", 32'(res_carry), 32'(mon_e.c));
        chk("res_zero", 32'(res_zero), 32'(mon_e.z));
        stamps.push_back(cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_cmd(input logic m, input logic [2:0] op,
                          input logic [5:0] a, input logic [5:0] b, input exp_t e);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_modo  = m;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    while (!cmd_ready && n < 50) begin
      step(1);
      n++;
    end
    if (!cmd_ready) begin
      chk("push_ready_timeout", 32'(cmd_ready), 32'd1);
    end else begin
      sb.push_back(e);
      step(1);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((sb.size() != 0 || res_valid) && n < maxc) begin
      step(1);
      n++;
    end
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("drain_res_valid", 32'(res_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs
    rst = 1'b0;
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'($urandom);
      cmd_a     = 6'($urandom);
      cmd_b     = 6'($urandom);
      cmd_op    = 3'($urandom);
      cmd_modo  = 1'($urandom);
      res_ready = 1'($urandom);
      step(1);
    end
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    rst = 1'b1;
    step(3);
    chk("idle_res_valid", 32'(res_valid), 32'd0);
    chk("idle_level", 32'(level), 32'd0);
    chk("idle_alu_a", 32'(alu_a), 32'd0);

    // Add with carry: 40 + 30 = 70 -> 6, carry 1
    push_cmd(1'b0, OP_ADD, 6'd40, 6'd30, '{d: 6'd6, c: 1'b1, z: 1'b0});
    step(1);
    chk("add_alu_a_E1", 32'(alu_a), 32'd40);
    chk("add_alu_b_E1", 32'(alu_b), 32'd30);
    chk("add_valid_E1", 32'(res_valid), 32'd0);
    step(1);
    chk("add_valid_E2", 32'(res_valid), 32'd0);
    step(1);
    chk("add_valid_E3", 32'(res_valid), 32'd1);
    chk("add_data_E3", 32'(res_data), 32'd6);
    step(2);
    chk("add_hold_data", 32'(res_data), 32'd6);
    res_ready = 1'b1;
    drain(20);

    // Logic XOR with stale ULA carry of 1 -> carry forced 0
    push_cmd(1'b1, OP_XOR, 6'h2A, 6'h2A, '{d: 6'd0, c: 1'b0, z: 1'b1});
    drain(20);

    // Backpressure: 5 accepted, 6th refused
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push_cmd(1'b0, OP_ADD, 6'(i + 1), 6'd2, '{d: 6'(i + 3), c: 1'b0, z: 1'b0});
    chk("full_level", 32'(level), 32'd4);
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1;
    cmd_a = 6'd50; cmd_b = 6'd1; cmd_op = OP_ADD; cmd_modo = 1'b0;
    step(2);
    chk("full_refused_level", 32'(level), 32'd4);
    chk("full_hold_valid", 32'(res_valid), 32'd1);
    chk("full_hold_data", 32'(res_data), 32'd3);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    step(1);
    chk("after_pop_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("after_pop_level", 32'(level), 32'd3);
    drain(60);

    // Streaming A+1, one result every three cycles
    stamps.delete();
    for (int i = 0; i < 4; i++)
      push_cmd(1'b0, OP_INC_A, 6'(i), 6'd0, '{d: 6'(i + 1), c: 1'b0, z: 1'b0});
    drain(40);
    chk("stream_count", 32'(stamps.size()), 32'd4);
    for (int i = 1; i < stamps.size(); i++)
      chk("stream_gap", 32'(stamps[i] - stamps[i-1]), 32'd3);

    // Mid-op reset during CAPTURE with 2 queued
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push_cmd(1'b0, OP_ADD, 6'd9, 6'(i), '{d: 6'(9 + i), c: 1'b0, z: 1'b0});
    chk("pre_rst_level", 32'(level), 32'd2);
    rst = 1'b0;
    #1;
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_alu_a", 32'(alu_a), 32'd0);
    sb.delete();
    step(1);
    rst = 1'b1;
    step(2);
    chk("post_rst_valid", 32'(res_valid), 32'd0);
    chk("post_rst_level", 32'(level), 32'd0);
    push_cmd(1'b0, OP_DEC_B, 6'd5, 6'd0, '{d: 6'd63, c: 1'b1, z: 1'b0});
    res_ready = 1'b1;
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
